// File: rtl/pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// pipe_stage_buffer
//
// Pipeline stage register that carries a WIDTH-bit bundle between two
// pipeline stages under a valid/ready handshake. It has a synchronous flush
// that turns the stage into a bubble. Bubbles (flushed or reset contents)
// are all-zero bundles.
//
// SKID = 1 : two-entry skid buffer. in_ready is a flop, so there is no
//            combinational path from out_ready to in_ready.
// SKID = 0 : single register. in_ready = out_ready | ~out_valid, which is
//            combinational.
//
// Ports
//   clk        clock, rising-edge active
//   rst        asynchronous, active-low reset
//   flush      synchronous kill of all buffered contents
//   in_valid   upstream holds a valid bundle
//   in_ready   stage can accept this cycle
//   in_data    upstream bundle
//   out_valid  out_data is valid
//   out_ready  downstream accepts this cycle
//   out_data   bundle presented downstream (main register M)
//   count      occupancy: 0..2 when SKID = 1, 0..1 when SKID = 0
// ---------------------------------------------------------------------------
module pipe_stage_buffer #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    generate
        if (SKID != 0) begin : g_skid
            // The state encoding is the occupancy itself, so count is the
            // state register.
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t           state_q, state_d;
            logic [WIDTH-1:0] m_q, m_d;
            logic [WIDTH-1:0] s_q, s_d;
            logic             in_ready_q, in_ready_d;
            logic             in_fire, out_fire;

            assign in_fire  = in_valid & in_ready_q;
            assign out_fire = (state_q != EMPTY) & out_ready;

            always_comb begin
                state_d = state_q;
                m_d     = m_q;
                s_d     = s_q;
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            m_d     = in_data;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            m_d = in_data;
                        end else if (in_fire) begin
                            // Downstream stalled: the extra bundle is
                            // parked in the skid register.
                            s_d     = in_data;
                            state_d = FULL;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            m_d     = s_q;
                            state_d = ONE;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
                // Flush overrides every other event. Any handshake in this
                // cycle still completes, but its bundle is discarded.
                if (flush) begin
                    state_d = EMPTY;
                    m_d     = '0;
                    s_d     = '0;
                end
                // in_ready is registered. It depends only on the next
                // state, never on this cycle's out_ready.
                in_ready_d = (state_d != FULL);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q    <= EMPTY;
                    m_q        <= '0;
                    s_q        <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    m_q        <= m_d;
                    s_q        <= s_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != EMPTY);
            assign out_data  = m_q;
            assign count     = state_q;
        end else begin : g_plain
            logic [WIDTH-1:0] m_q, m_d;
            logic             valid_q, valid_d;
            logic             in_fire, out_fire;
            logic             in_ready_c;

            // The stage accepts a new bundle whenever the current one is
            // leaving or there is none.
            assign in_ready_c = out_ready | ~valid_q;
            assign in_fire    = in_valid & in_ready_c;
            assign out_fire   = valid_q & out_ready;

            always_comb begin
                m_d     = m_q;
                valid_d = valid_q;
                if (in_fire) begin
                    m_d     = in_data;
                    valid_d = 1'b1;
                end else if (out_fire) begin
                    valid_d = 1'b0;
                end
                if (flush) begin
                    m_d     = '0;
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_q     <= '0;
                    valid_q <= 1'b0;
                end else begin
                    m_q     <= m_d;
                    valid_q <= valid_d;
                end
            end

            assign in_ready  = in_ready_c;
            assign out_valid = valid_q;
            assign out_data  = m_q;
            assign count     = {1'b0, valid_q};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Testbench for pipe_stage_buffer. Six instances cover SKID 1/0 at WIDTH 32, 1
// and 100. A single queue serves as a reference model of the contents of the
// instance under test. Only one instance is exercised at a time.
module tb_pipe_stage_buffer;

   localparam int NDUT = 6;

   logic clock;
   logic rstN;

   logic         inValidA  [NDUT];
   logic         outReadyA [NDUT];
   logic         flushA    [NDUT];
   logic         inReadyA  [NDUT];
   logic         outValidA [NDUT];
   logic [99:0]  inDataA   [NDUT];
   logic [99:0]  outDataA  [NDUT];
   logic [1:0]   countA    [NDUT];

   logic [99:0]  sb[$];
   int           vectors;
   int           miscompares;
   logic         lastInFire;

   // Instances: 0/1 = WIDTH 32, 2/3 = WIDTH 1, 4/5 = WIDTH 100; even = SKID 1
   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = (g < 2) ? 32 : ((g < 4) ? 1 : 100);
      localparam int S = (g % 2 == 0) ? 1 : 0;
      logic [W-1:0] inD;
      logic [W-1:0] outD;
      assign inD         = inDataA[g][W-1:0];
      assign outDataA[g] = 100'(outD);
      pipe_stage_buffer #(.WIDTH(W), .SKID(S)) u_dut (
         .clk       (clock),
         .rst       (rstN),
         .flush     (flushA[g]),
         .in_valid  (inValidA[g]),
         .in_ready  (inReadyA[g]),
         .in_data   (inD),
         .out_valid (outValidA[g]),
         .out_ready (outReadyA[g]),
         .out_data  (outD),
         .count     (countA[g])
      );
   end

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, wanted completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int widthOf(input int g);
      return (g < 2) ? 32 : ((g < 4) ? 1 : 100);
   endfunction

   function automatic bit skidOf(input int g);
      return (g % 2) == 0;
   endfunction

   // Counts one comparison and reports it if it does not match
   task automatic checkOutput(input string tag, input logic [99:0] observed, input logic [99:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle on instance g. The reference queue is updated from the
   // handshakes seen before the edge, and the instance is compared against it
   // after the edge.
   task automatic applyStimulus(input int g, input logic iv, input logic [99:0] d,
                                input logic ordy, input logic fl);
      logic inFire;
      logic outFire;
      @(negedge clock);
      inValidA[g]  = iv;
      inDataA[g]   = d;
      outReadyA[g] = ordy;
      flushA[g]    = fl;
      #1;
      if (!skidOf(g))
         checkOutput("comb_ready", 100'(inReadyA[g]), 100'(ordy | (sb.size() == 0)));
      inFire  = iv & inReadyA[g];
      outFire = outValidA[g] & ordy;
      if (outFire) begin
         checkOutput("sb_nonempty", 100'(sb.size() != 0), 100'(1));
         if (sb.size() != 0) begin
            checkOutput("sb_data", outDataA[g], sb[0]);
            void'(sb.pop_front());
         end
      end
      if (fl) sb.delete();
      else if (inFire) sb.push_back(d);
      lastInFire = inFire;
      @(posedge clock);
      #1;
      checkOutput("count", 100'(countA[g]), 100'(sb.size()));
      checkOutput("out_valid", 100'(outValidA[g]), 100'(sb.size() != 0));
      if (sb.size() != 0) checkOutput("out_data", outDataA[g], sb[0]);
      if (skidOf(g)) checkOutput("reg_ready", 100'(inReadyA[g]), 100'(sb.size() != 2));
      checkOutput("count_bound", 100'(countA[g] <= (skidOf(g) ? 2'd2 : 2'd1)), 100'(1));
   endtask

   // Resets every instance and checks the reset state of all of them
   task automatic doReset;
      @(negedge clock);
      for (int i = 0; i < NDUT; i++) begin
         inValidA[i] = 1'b0; outReadyA[i] = 1'b0; flushA[i] = 1'b0; inDataA[i] = '0;
      end
      rstN = 1'b0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         checkOutput("rst_out_valid", 100'(outValidA[i]), 100'(0));
         checkOutput("rst_out_data", outDataA[i], 100'(0));
         checkOutput("rst_count", 100'(countA[i]), 100'(0));
         checkOutput("rst_in_ready", 100'(inReadyA[i]), 100'(1));
      end
      @(negedge clock);
      rstN = 1'b1;
      sb.delete();
   endtask

   initial begin
      logic [127:0] r;
      logic [99:0]  mask;
      int           idx;
      int           guard;
      vectors     = 0;
      miscompares = 0;
      lastInFire  = 1'b0;
      rstN        = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         inValidA[i] = 1'b0; outReadyA[i] = 1'b0; flushA[i] = 1'b0; inDataA[i] = '0;
      end

      // Streaming at full rate: each bundle appears one cycle after it is accepted
      doReset();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(0, 1'b1, 100'(i), 1'b1, 1'b0);
         checkOutput("stream_data", outDataA[0], 100'(i));
         checkOutput("stream_count", 100'(countA[0]), 100'(1));
         checkOutput("stream_ready", 100'(inReadyA[0]), 100'(1));
      end
      applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);

      // Backpressure: out_ready is held low for three cycles after 0xA2 appears
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 100'(8'hA0 + i), 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 100'(8'hA3), 1'b0, 1'b0);
      checkOutput("bp_count_full", 100'(countA[0]), 100'(2));
      checkOutput("bp_ready_low", 100'(inReadyA[0]), 100'(0));
      checkOutput("bp_hold_a2", outDataA[0], 100'(8'hA2));
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1'b1, 100'(8'hA4), 1'b0, 1'b0);
         checkOutput("bp_still_a2", outDataA[0], 100'(8'hA2));
      end
      idx = 4;
      guard = 0;
      while (idx < 8 && guard < 40) begin
         applyStimulus(0, 1'b1, 100'(8'hA0 + idx), 1'b1, 1'b0);
         if (lastInFire) idx++;
         guard++;
      end
      checkOutput("bp_all_accepted", 100'(idx), 100'(8));
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);

      // A full buffer drains to empty in two cycles when nothing new arrives
      doReset();
      applyStimulus(0, 1'b1, 100'(8'h11), 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 100'(8'h22), 1'b0, 1'b0);
      applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("drain_count", 100'(countA[0]), 100'(0));

      // Flush while full, with a new bundle offered in the same cycle
      doReset();
      applyStimulus(0, 1'b1, 100'(8'h11), 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 100'(8'h22), 1'b0, 1'b0);
      checkOutput("fl_full", 100'(countA[0]), 100'(2));
      applyStimulus(0, 1'b1, 100'(8'h33), 1'b0, 1'b1);
      checkOutput("fl_out_valid", 100'(outValidA[0]), 100'(0));
      checkOutput("fl_out_data", outDataA[0], 100'(0));
      checkOutput("fl_count", 100'(countA[0]), 100'(0));
      checkOutput("fl_in_ready", 100'(inReadyA[0]), 100'(1));
      applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);

      // With SKID=0, in_ready follows out_ready within the same cycle
      doReset();
      applyStimulus(1, 1'b1, 100'(5), 1'b0, 1'b0);
      @(negedge clock);
      inValidA[1] = 1'b1; inDataA[1] = 100'(6); outReadyA[1] = 1'b0;
      #1;
      checkOutput("s0_ready_low", 100'(inReadyA[1]), 100'(0));
      outReadyA[1] = 1'b1;
      #1;
      checkOutput("s0_ready_high", 100'(inReadyA[1]), 100'(1));
      outReadyA[1] = 1'b0;
      #1;
      applyStimulus(1, 1'b1, 100'(6), 1'b1, 1'b0);
      checkOutput("s0_b2b", outDataA[1], 100'(6));
      applyStimulus(1, 1'b1, 100'(9), 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 100'(10), 1'b1, 1'b1);
      checkOutput("s0_fl_valid", 100'(outValidA[1]), 100'(0));
      checkOutput("s0_fl_data", outDataA[1], 100'(0));

      // Asynchronous reset taken between clock edges while full
      doReset();
      applyStimulus(0, 1'b1, 100'(8'h44), 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 100'(8'h55), 1'b0, 1'b0);
      @(negedge clock);
      inValidA[0] = 1'b0;
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("ar_out_valid", 100'(outValidA[0]), 100'(0));
      checkOutput("ar_out_data", outDataA[0], 100'(0));
      checkOutput("ar_count", 100'(countA[0]), 100'(0));
      #1;
      rstN = 1'b1;
      sb.delete();
      applyStimulus(0, 1'b1, 100'(8'h77), 1'b1, 1'b0);
      checkOutput("ar_fresh", outDataA[0], 100'(8'h77));
      checkOutput("ar_fresh_valid", 100'(outValidA[0]), 100'(1));

      // Random soak: WIDTH 1 and 100, both SKID values, rare flushes
      for (int g = 2; g < NDUT; g++) begin
         doReset();
         mask = ~100'd0 >> (100 - widthOf(g));
         for (int c = 0; c < 400; c++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(g, 1'($urandom_range(0, 9) < 7), r[99:0] & mask,
                          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 49) == 0));
         end
         for (int c = 0; c < 3; c++) applyStimulus(g, 1'b0, '0, 1'b1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
